// File: rtl/ssd_scan_ctl_if.sv
// ============================================================================
// Module      : ssd_scan_ctl_if
// Description : Digit snapshot inputs and multiplexed display outputs of the
//               seven-segment scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ssd_scan_ctl_if;
  logic [3:0] bcd3;
  logic [3:0] bcd2;
  logic [3:0] bcd1;
  logic [3:0] bcd0;
  logic [3:0] dp;
  logic       load;
  logic       blank_lz;
  logic [3:0] ssd_ctl;
  logic [7:0] segs;

  modport master (
    output bcd3, bcd2, bcd1, bcd0, dp, load, blank_lz,
    input  ssd_ctl, segs
  );

  modport slave (
    input  bcd3, bcd2, bcd1, bcd0, dp, load, blank_lz,
    output ssd_ctl, segs
  );
endinterface

`default_nettype wire

// File: rtl/ssd_scan_ctl.sv
// ============================================================================
// Module      : ssd_scan_ctl
// Description : Snapshots four BCD digits and scans them onto a 4-digit
//               common-anode seven-segment display with leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ssd_scan_ctl #(
  parameter int DIV_BITS = 17
) (
  input  logic             clk,
  input  logic             rst,
  ssd_scan_ctl_if.slave    bus
);

  logic [DIV_BITS-1:0] cnt_q, cnt_d;
  logic [1:0]          sel_q, sel_d;
  logic [15:0]         dig_q, dig_d;
  logic [3:0]          dp_q, dp_d;
  logic [3:0]          ssd_ctl_q, ssd_ctl_d;
  logic [7:0]          segs_q, segs_d;

  logic                w_tick;
  logic [3:0]          w_digit;
  logic                w_blank;
  logic [7:0]          w_pat;
  logic                w_lz3, w_lz2, w_lz1;

  always_comb begin
    w_tick = &cnt_q;
    cnt_d  = cnt_q + 1'b1;
    sel_d  = w_tick ? sel_q + 2'd1 : sel_q;
    dig_d  = bus.load ? {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0} : dig_q;
    dp_d   = bus.load ? bus.dp : dp_q;

    w_digit = dig_q[4*sel_q +: 4];

    // A digit is a leading zero only if every more-significant digit is too
    w_lz3 = (dig_q[15:12] == 4'd0);
    w_lz2 = w_lz3 && (dig_q[11:8] == 4'd0);
    w_lz1 = w_lz2 && (dig_q[7:4] == 4'd0);

    w_blank = 1'b0;
    case (sel_q)
      2'd1:    w_blank = bus.blank_lz && w_lz1;
      2'd2:    w_blank = bus.blank_lz && w_lz2;
      2'd3:    w_blank = bus.blank_lz && w_lz3;
      default: w_blank = 1'b0;
    endcase

    case (w_digit)
      4'd0:    w_pat = 8'b0000_0011;
      4'd1:    w_pat = 8'b1001_1111;
      4'd2:    w_pat = 8'b0010_0101;
      4'd3:    w_pat = 8'b0000_1101;
      4'd4:    w_pat = 8'b1001_1001;
      4'd5:    w_pat = 8'b0100_1001;
      4'd6:    w_pat = 8'b0100_0001;
      4'd7:    w_pat = 8'b0001_1111;
      4'd8:    w_pat = 8'b0000_0001;
      4'd9:    w_pat = 8'b0000_1001;
      default: w_pat = 8'b1111_1101;
    endcase

    if (w_blank) begin
      ssd_ctl_d = 4'b1111;
      segs_d    = 8'hFF;
    end else begin
      ssd_ctl_d = ~(4'b0001 << sel_q);
      segs_d    = {w_pat[7:1], ~dp_q[sel_q]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      sel_q     <= 2'd0;
      dig_q     <= 16'd0;
      dp_q      <= 4'd0;
      ssd_ctl_q <= 4'b1111;
      segs_q    <= 8'hFF;
    end else begin
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      dig_q     <= dig_d;
      dp_q      <= dp_d;
      ssd_ctl_q <= ssd_ctl_d;
      segs_q    <= segs_d;
    end
  end

  assign bus.ssd_ctl = ssd_ctl_q;
  assign bus.segs    = segs_q;

endmodule

`default_nettype wire

// File: doc/ssd_scan_ctl.md
Name: ssd_scan_ctl

Overview:
Downstream display stage for the binary-to-BCD converter. It snapshots four BCD digits (plus per-digit decimal points) on a load strobe and time-multiplexes them onto a 4-digit common-anode seven-segment display. Outputs are the active-low anode enables and the active-low segment bus. Optional leading-zero blanking is supported.

Parameters:
DIV_BITS, 17, width of the refresh prescaler; the scan advances one digit every 2^DIV_BITS clk cycles (benches use 2)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
bcd3  input  4  thousands digit from the converter
bcd2  input  4  hundreds digit
bcd1  input  4  tens digit
bcd0  input  4  units digit
dp  input  4  decimal-point request per digit (bit n = digit n), active-high
load  input  1  snapshot strobe; captures bcd3..bcd0 and dp at this clk edge
blank_lz  input  1  1 = blank leading zeros (digits 3..1)
ssd_ctl  output  4  anode enables, active-low; bit n drives digit n (bit 0 = rightmost)
segs  output  8  segments active-low, {a,b,c,d,e,f,g,dp}

Behaviour:
- Interface: one clock `clk`. Reset `rst` is asynchronous and active-high; asserting it forces the reset state immediately, regardless of clk.
- Reset state:
  - prescaler cnt = 0, scan index sel = 0
  - latched digits d3..d0 = 0, latched dp = 0
  - ssd_ctl = 4'b1111 (all off), segs = 8'hFF
- Prescaler:
  - cnt (DIV_BITS wide) increments every clk and wraps from all-ones to 0.
  - tick = (cnt == all-ones).
- Scan index:
  - sel (2 bits) increments on tick and wraps 3 -> 0.
  - sel and cnt are never affected by load.
- Snapshot:
  - When load = 1 at an edge, d3..d0 and dp take the inputs.
  - With load = 0, the latched values hold.
  - If load coincides with a tick, both take effect at that edge.
- Outputs are registered and recomputed every clk from the current sel, latched digits and blank_lz. They reflect state with one cycle of latency: a change to sel or to the latched data appears on ssd_ctl/segs one edge later. The first edge after reset release drives digit 0.
- Anode map (unblanked): sel 0 -> 4'b1110, 1 -> 4'b1101, 2 -> 4'b1011, 3 -> 4'b0111.
- Segment encoding (dp bit = 1) for 0..9: 0000_0011, 1001_1111, 0010_0101, 0000_1101, 1001_1001, 0100_1001, 0100_0001, 0001_1111, 0000_0001, 0000_1001.
- Codes 10..15 display a dash: 1111_1101.
- Decimal point: if the latched dp bit for the selected digit = 1, segs[0] = 0; otherwise segs[0] = 1.
- Leading-zero blanking, applied only when blank_lz = 1:
  - digit3 is blank if d3 == 0
  - digit2 is blank if d3 == d2 == 0
  - digit1 is blank if d3 == d2 == d1 == 0
  - digit0 is never blank
  - A blanked slot drives ssd_ctl = 4'b1111 and segs = 8'hFF, including the dp bit.
- blank_lz is not latched; it takes effect on the next output register update.
- Exactly one anode is low at any time, except in the reset state and in blanked slots.

Test Plan:
1. Reset and idle scan. Setup: DIV_BITS = 2; assert rst mid-scan, then release with no load.
   - While rst is asserted: ssd_ctl = 1111 and segs = FF, immediately without waiting for an edge.
   - After release: ssd_ctl cycles 1110, 1101, 1011, 0111, each held for 4 clk; segs = 0000_0011 in every slot.
2. Load 1234. Stimulus: load with bcd = 1,2,3,4 and dp = 0.
   - Outputs: digit0 -> segs 1001_1001, digit1 -> 0000_1101, digit2 -> 0010_0101, digit3 -> 1001_1111.
   - Inputs changed afterwards with load = 0 must not change the display.
3. Leading-zero blanking on 0007. Stimulus: load 0,0,0,7, blank_lz = 1.
   - Digit0 shows 0001_1111; slots 1..3 show ssd_ctl = 1111 and segs = FF.
   - With blank_lz = 0, all four digits are lit and digits 3..1 show 0000_0011.
   - Repeat with 0000 and blank_lz = 1: only digit0 is lit, showing 0000_0011.
4. Decimal point and invalid code. Stimulus: load bcd0 = 12 and dp = 4'b0001.
   - Digit0 segs = 1111_1100 (dash with dp lit).
   - Other digits keep dp off (segs[0] = 1).
5. Load coincident with tick. Stimulus: assert load on the edge where cnt = 3 (all-ones).
   - sel advances and the new data latches at that same edge.
   - The next edge shows the new digit for the new sel.
   - The cnt sequence is undisturbed.
